// File: rtl/alu181_serial_seq_pkg.sv
// rtl/alu181_serial_seq_pkg.sv - shared constants and state encoding for the slice-serial 74181 ALU
package alu181_serial_seq_pkg;

    // Common function select codes
    localparam logic [3:0] ALU_S_ADD   = 4'b1001;
    localparam logic [3:0] ALU_S_SUB   = 4'b0110;
    localparam logic [3:0] ALU_S_PASSA = 4'b0000;

    // Mode select
    localparam logic ALU_M_ARITH = 1'b0;
    localparam logic ALU_M_LOGIC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu181_slice.sv
// rtl/alu181_slice.sv - combinational SLICE-bit 74181 cell group with carry in/out
//   i_a, i_b : operand slice bits
//   i_s      : function select s[3:0]
//   i_m      : 0 = arithmetic, 1 = logic
//   i_cin    : carry into the slice LSB
//   o_f      : slice result bits
//   o_cout   : carry out of the slice MSB (0 in logic mode)
module alu181_slice
    import alu181_serial_seq_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic [3:0]       i_s,
    input  logic             i_m,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_f,
    output logic             o_cout
);

    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;
    logic [SLICE:0]   w_sum;

    assign w_x = i_a | (i_b & {SLICE{i_s[0]}}) | (~i_b & {SLICE{i_s[1]}});
    assign w_y = (i_a & ~i_b & {SLICE{i_s[2]}}) | (i_a & i_b & {SLICE{i_s[3]}});

    // One extra bit on the adder captures the slice carry out
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{SLICE{1'b0}}, i_cin};

    assign o_f    = (i_m == ALU_M_LOGIC) ? ~(w_x ^ w_y) : w_sum[SLICE-1:0];
    assign o_cout = (i_m == ALU_M_LOGIC) ? 1'b0 : w_sum[SLICE];

endmodule

// File: rtl/alu181_serial_seq.sv
// rtl/alu181_serial_seq.sv - multi-cycle slice-serial 74181-style ALU with start/busy/done handshake
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : request, sampled only while busy=0
//   a, b       : operands; s : function select; m : mode; cin : carry in
//   f, cout, eq: registered result, MSB carry out, all-ones flag
//   busy, done : operation in progress, one-cycle completion pulse
module alu181_serial_seq
    import alu181_serial_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             eq,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // The result shift register holds only the slices not yet final, so at
    // least two slices are needed for it to have a nonzero width.
    generate
        if ((WIDTH % SLICE) != 0 || WIDTH <= SLICE) begin : g_bad_params
            $error("alu181_serial_seq: WIDTH must be a multiple of SLICE and larger than SLICE");
        end
    endgenerate

    alu_state_t             r_state;
    alu_state_t             w_state_next;
    logic                   w_accept;
    logic                   w_last;

    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [3:0]             r_s;
    logic                   r_m;
    logic                   r_carry;
    logic [WIDTH-SLICE-1:0] r_acc;

    logic [WIDTH-1:0]       r_f;
    logic                   r_cout;
    logic                   r_eq;
    logic                   r_busy;
    logic                   r_done;

    logic [SLICE-1:0]       w_slice_f;
    logic                   w_slice_cout;
    logic [WIDTH-1:0]       w_acc_next;

    // Operand registers shift right each slice, so the slice always sees bits [SLICE-1:0]
    alu181_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (r_a[SLICE-1:0]),
        .i_b    (r_b[SLICE-1:0]),
        .i_s    (r_s),
        .i_m    (r_m),
        .i_cin  (r_carry),
        .o_f    (w_slice_f),
        .o_cout (w_slice_cout)
    );

    // New slice enters at the top; after N slices the LSB slice has reached bit 0
    assign w_acc_next = {w_slice_f, r_acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_eq    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_s     <= s;
                r_m     <= m;
                r_carry <= cin;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_a     <= r_a >> SLICE;
                r_b     <= r_b >> SLICE;
                r_acc   <= w_acc_next[WIDTH-1:SLICE];
                r_carry <= w_slice_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_f    <= w_acc_next;
                    r_cout <= w_slice_cout;
                    r_eq   <= &w_acc_next;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign f    = r_f;
    assign cout = r_cout;
    assign eq   = r_eq;
    assign busy = r_busy;
    assign done = r_done;

endmodule
